// File: rtl/uart_cmd_decoder.sv
// Two-byte UART command decoder: a command byte followed by a sensor-address byte
// yields a held command with a valid/ready handshake; protocol errors raise a one-cycle strobe.
module uart_cmd_decoder #(
  parameter int         TIMEOUT_CYCLES = 2500000,
  parameter logic [7:0] MAX_CMD        = 8'h05,
  parameter logic [4:0] MAX_ADDR       = 5'd31
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       rx_rdy_clr,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_code,
  output logic [4:0] cmd_addr,
  output logic       err_pulse,
  output logic [2:0] err_code
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ERR_CMD     = 3'b001;
  localparam logic [2:0] ERR_ADDR    = 3'b010;
  localparam logic [2:0] ERR_TIMEOUT = 3'b011;
  localparam logic [2:0] ERR_OVERRUN = 3'b100;

  typedef enum logic [1:0] {IDLE, WAIT_ADDR, ISSUE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       code_nxt;
  logic [4:0]       addr_nxt;
  logic             valid_nxt;
  logic             err_nxt;
  logic [2:0]       errc_nxt;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cmd_code   <= 8'h00;
      cmd_addr   <= 5'd0;
      cmd_valid  <= 1'b0;
      rx_rdy_clr <= 1'b0;
      err_pulse  <= 1'b0;
      err_code   <= 3'b000;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cmd_code   <= code_nxt;
      cmd_addr   <= addr_nxt;
      cmd_valid  <= valid_nxt;
      rx_rdy_clr <= rx_rdy;
      err_pulse  <= err_nxt;
      err_code   <= errc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    code_nxt  = cmd_code;
    addr_nxt  = cmd_addr;
    valid_nxt = cmd_valid;
    err_nxt   = 1'b0;
    errc_nxt  = err_code;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rx_rdy) begin
          if (rx_data <= MAX_CMD) begin
            code_nxt  = rx_data;
            state_nxt = WAIT_ADDR;
          end else begin
            err_nxt  = 1'b1;
            errc_nxt = ERR_CMD;
          end
        end
      end
      WAIT_ADDR: begin
        cnt_nxt = cnt + 1'b1;
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rx_rdy) begin
          if (rx_data <= {3'b000, MAX_ADDR}) begin
            addr_nxt  = rx_data[4:0];
            valid_nxt = 1'b1;
            state_nxt = ISSUE;
          end else begin
            err_nxt   = 1'b1;
            errc_nxt  = ERR_ADDR;
            state_nxt = IDLE;
          end
        end else if (cnt == CNT_LAST) begin
          err_nxt   = 1'b1;
          errc_nxt  = ERR_TIMEOUT;
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_valid && cmd_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
        // Overrun bytes are dropped without touching the held command.
        if (rx_rdy) begin
          err_nxt  = 1'b1;
          errc_nxt = ERR_OVERRUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule
